uart_cmd_wrapper: RTL and testbench

UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

---
 rtl/uart_cmd_wrapper_if.sv | 29 ++
 rtl/uart_cmd_wrapper.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_wrapper_if.sv
// uart_cmd_wrapper_if
//   Groups the command/response handshake between the UART wrapper and the
//   logic that consumes commands and produces response bytes.
//   Signals:
//     cmd[15:0]    assembled command {first byte, second byte}
//     cmd_rdy      command valid, level held until clr_cmd_rdy
//     clr_cmd_rdy  one-cycle acknowledge of cmd from the consumer
//     resp[7:0]    response byte, sampled only with send_resp
//     send_resp    one-cycle request to transmit resp
//     resp_sent    one-cycle pulse in the last cycle of the response stop bit
//   Modports: slave = the UART wrapper, master = the command consumer.
interface uart_cmd_wrapper_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper
//   Full-duplex 8N1 UART that assembles two received bytes into a 16-bit
//   command and transmits single response bytes on request.
//   Ports:
//     clk    system clock, posedge
//     rst_n  asynchronous active-low reset
//     RX     serial input from host (asynchronous, idles high)
//     TX     serial output to host (idles high)
//     bus    uart_cmd_wrapper_if.slave: cmd/cmd_rdy/clr_cmd_rdy and
//            resp/send_resp/resp_sent handshakes
//   Parameters:
//     BAUD_DIV  clk cycles per serial bit (16..65535)
//     TIMEOUT   max clk cycles allowed between the high and low command bytes
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned TIMEOUT  = 1 << 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  uart_cmd_wrapper_if.slave bus
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);
  localparam int          TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  typedef enum logic       {RX_IDLE, RX_BUSY}          rx_state_e;
  typedef enum logic       {TX_IDLE, TX_BUSY}          tx_state_e;
  typedef enum logic [1:0] {ST_HIGH, ST_LOW, ST_FULL}  asm_state_e;

  // RX synchronizer plus one extra flop for falling-edge detection; all
  // preset high so a reset never looks like a start bit.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver. Bit counter: 0 = start bit, 1..8 = data, 9 = stop.
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_baud_q, rx_baud_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Edge (not level) detection: after a framing error the line must
        // return high before another start is accepted.
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_BUSY;
          rx_baud_d  = '0;
          rx_bit_d   = '0;
        end
      end
      RX_BUSY: begin
        // First interval is half a bit to land on the start-bit midpoint.
        if (rx_baud_q == ((rx_bit_q == 4'd0) ? HALF_LAST : BAUD_LAST)) begin
          rx_baud_d = '0;
          if (rx_bit_q == 4'd0) begin
            if (rx_sync_q) rx_state_d = RX_IDLE;
            else           rx_bit_d   = 4'd1;
          end else if (rx_bit_q == 4'd9) begin
            rx_valid   = rx_sync_q;
            rx_state_d = RX_IDLE;
            rx_bit_d   = '0;
          end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 4'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Command assembly.
  asm_state_e      asm_q, asm_d;
  logic [15:0]     cmd_q, cmd_d;
  logic [TO_W-1:0] to_q, to_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= ST_HIGH;
      cmd_q <= '0;
      to_q  <= '0;
    end else begin
      asm_q <= asm_d;
      cmd_q <= cmd_d;
      to_q  <= to_d;
    end
  end

  always_comb begin
    asm_d = asm_q;
    cmd_d = cmd_q;
    to_d  = to_q;
    case (asm_q)
      ST_HIGH: begin
        if (rx_valid) begin
          cmd_d[15:8] = rx_shift_q;
          to_d        = '0;
          asm_d       = ST_LOW;
        end
      end
      ST_LOW: begin
        // A byte arriving on the timeout cycle itself still completes cmd.
        if (rx_valid) begin
          cmd_d[7:0] = rx_shift_q;
          asm_d      = ST_FULL;
        end else if (to_q == TO_LIM) begin
          asm_d = ST_HIGH;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_FULL: begin
        // Received bytes are dropped here, including one coincident with clear.
        if (bus.clr_cmd_rdy) asm_d = ST_HIGH;
      end
      default: asm_d = ST_HIGH;
    endcase
  end

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = (asm_q == ST_FULL);

  // Transmitter. Bit counter: 0 = start bit, 1..8 = data, 9 = stop.
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_baud_q, tx_baud_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.send_resp) begin
          tx_state_d = TX_BUSY;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_shift_d = bus.resp;
        end
      end
      TX_BUSY: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            // Shift only after a data bit so shift[0] is the bit on the line.
            if (tx_bit_q != 4'd0) tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_baud_d = tx_baud_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX decoded from registers only, so reset forces it high immediately.
  assign TX = (tx_state_q == TX_IDLE) || (tx_bit_q == 4'd9) ||
              ((tx_bit_q != 4'd0) && tx_shift_q[0]);

  assign bus.resp_sent = (tx_state_q == TX_BUSY) && (tx_bit_q == 4'd9) &&
                         (tx_baud_q == BAUD_LAST);

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper
//   Drives serial frames into RX and response requests into the handshake
//   interface; a frame-level model predicts TX, resp_sent, cmd and cmd_rdy
//   for every clock cycle. Directed scenarios pin the model with literals.
module tb_uart_cmd_wrapper;
  localparam int B      = 16;
  localparam int TO     = 1000;
  localparam int HALF   = B / 2;
  // From the first clock edge that sees RX low to the stop-bit sample edge:
  // 2 synchronizer stages, start midpoint after HALF, then 9 bit periods.
  localparam int RX_LAT = 2 + HALF + 9 * B;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic RX    = 1'b1;
  logic TX;

  uart_cmd_wrapper_if bus ();

  uart_cmd_wrapper #(.BAUD_DIV(B), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .TX    (TX),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         t;
    logic [7:0] b;
    bit         ok;
  } rx_ev_t;
  rx_ev_t rxq[$];

  // Model state: command phase 0 = awaiting first byte, 1 = awaiting second,
  // 2 = command held.
  int         m_ph      = 0;
  logic [7:0] m_hi      = 8'h00;
  logic [7:0] m_lo      = 8'h00;
  int         m_t1      = 0;
  bit         m_tx_busy = 1'b0;
  int         m_tx_t0   = 0;
  logic [7:0] m_tx_b    = 8'h00;

  logic       tx_hist [0:10*B+19];
  int         rs_at;
  bit         seen;
  int         t_hit;
  int         pulses;
  logic [9:0] a5_seq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Serial frame onto RX: start, 8 data LSB-first, stop (optionally low).
  task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    rx_ev_t     ev;
    f = {stop_ok, b, 1'b0};
    @(negedge clk);
    ev.t  = cyc + 1 + RX_LAT;
    ev.b  = b;
    ev.ok = stop_ok;
    rxq.push_back(ev);
    for (int k = 0; k < 10; k++) begin
      RX = f[k];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.resp      = b;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    bus.resp      = 8'($urandom);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic wait_rdy(input string nm, input int lim);
    bit got;
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      got = bus.cmd_rdy;
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_sent(input string nm, input int lim);
    bit got;
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      got = bus.resp_sent;
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  // Per-cycle scoreboard, evaluated just after each rising edge.
  initial begin : scoreboard
    rx_ev_t     ev;
    bit         have_b;
    logic [7:0] b;
    logic       exp_tx, exp_rs;
    int         d, k;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        m_ph      = 0;
        m_hi      = 8'h00;
        m_lo      = 8'h00;
        m_tx_busy = 1'b0;
        rxq.delete();
      end else begin
        have_b = 1'b0;
        b      = 8'h00;
        while (rxq.size() > 0 && rxq[0].t <= cyc) begin
          ev = rxq.pop_front();
          if (ev.t == cyc && ev.ok) begin
            have_b = 1'b1;
            b      = ev.b;
          end
        end
        case (m_ph)
          0: if (have_b) begin m_hi = b; m_ph = 1; m_t1 = cyc; end
          1: if (have_b) begin
               if (cyc - m_t1 <= TO + 1) begin
                 m_lo = b;
                 m_ph = 2;
               end else begin
                 // Partial command timed out: this byte starts a new one.
                 m_hi = b;
                 m_t1 = cyc;
               end
             end
          default: if (bus.clr_cmd_rdy) m_ph = 0;
        endcase
        if (m_tx_busy && cyc > m_tx_t0 + 10 * B) m_tx_busy = 1'b0;
        if (!m_tx_busy && bus.send_resp) begin
          m_tx_busy = 1'b1;
          m_tx_t0   = cyc;
          m_tx_b    = bus.resp;
        end
      end
      exp_tx = 1'b1;
      exp_rs = 1'b0;
      if (m_tx_busy) begin
        d = cyc - m_tx_t0;
        if (d < 10 * B) begin
          k      = d / B;
          exp_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_tx_b[k-1];
          exp_rs = (d == 10 * B - 1);
        end
      end
      chk("TX",        {31'd0, TX},            {31'd0, exp_tx});
      chk("resp_sent", {31'd0, bus.resp_sent}, {31'd0, exp_rs});
      chk("cmd_rdy",   {31'd0, bus.cmd_rdy},   {31'd0, (m_ph == 2)});
      chk("cmd",       {16'd0, bus.cmd},       {16'd0, m_hi, m_lo});
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    a5_seq          = 10'b1101001010;
    repeat (5) @(negedge clk);
    chk("rst_TX",      {31'd0, TX},          32'd1);
    chk("rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("rst_cmd",     {16'd0, bus.cmd},     32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic assembly, drop while full, clear.
    rx_frame(8'h47, 1'b1);
    rx_frame(8'h12, 1'b1);
    wait_rdy("rdy_4712", 40);
    chk("cmd_4712", {16'd0, bus.cmd}, 32'h4712);
    rx_frame(8'h99, 1'b1);
    repeat (5) @(negedge clk);
    chk("cmd_held_4712", {16'd0, bus.cmd}, 32'h4712);
    chk("rdy_held",      {31'd0, bus.cmd_rdy}, 32'd1);
    clr_pulse();
    chk("rdy_cleared", {31'd0, bus.cmd_rdy}, 32'd0);
    rx_frame(8'h01, 1'b1);
    rx_frame(8'h02, 1'b1);
    wait_rdy("rdy_0102", 40);
    chk("cmd_0102", {16'd0, bus.cmd}, 32'h0102);

    // Clear coincident with a stop-bit sample while full: clear wins.
    fork
      rx_frame(8'h77, 1'b1);
      begin
        @(negedge clk);
        t_hit = cyc + 1 + RX_LAT;
        while (cyc < t_hit - 1) @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        chk("rdy_clr_wins", {31'd0, bus.cmd_rdy}, 32'd0);
      end
    join
    rx_frame(8'h21, 1'b1);
    rx_frame(8'h22, 1'b1);
    wait_rdy("rdy_2122", 40);
    chk("cmd_2122", {16'd0, bus.cmd}, 32'h2122);
    clr_pulse();

    // Response 0xA5 with an ignored second request mid-frame.
    fork
      begin
        send(8'hA5);
        repeat (48) @(negedge clk);
        send(8'h3C);
      end
      begin
        seen  = 1'b0;
        rs_at = -1;
        for (int i = 0; i < 10 && !seen; i++) begin
          @(negedge clk);
          seen = (TX == 1'b0);
        end
        chk("tx_start_seen", {31'd0, seen}, 32'd1);
        tx_hist[0] = TX;
        for (int i = 1; i < 10 * B + 20; i++) begin
          @(negedge clk);
          tx_hist[i] = TX;
          if (bus.resp_sent && rs_at < 0) rs_at = i;
        end
        for (int k = 0; k < 10; k++)
          chk($sformatf("a5_bit%0d", k), {31'd0, tx_hist[k*B+HALF]}, {31'd0, a5_seq[k]});
        chk("a5_sent_cycles", rs_at + 1, 10 * B);
        chk("a5_idle_after", {31'd0, tx_hist[10*B+10]}, 32'd1);
      end
    join

    // Timeout between the two bytes discards the first.
    rx_frame(8'h80, 1'b1);
    repeat (1100) @(negedge clk);
    rx_frame(8'h0A, 1'b1);
    rx_frame(8'h0B, 1'b1);
    wait_rdy("rdy_0A0B", 40);
    chk("cmd_0A0B", {16'd0, bus.cmd}, 32'h0A0B);
    clr_pulse();

    // Framing error frame is not accepted.
    rx_frame(8'h55, 1'b0);
    repeat (6) @(negedge clk);
    rx_frame(8'h33, 1'b1);
    rx_frame(8'h44, 1'b1);
    wait_rdy("rdy_3344", 40);
    chk("cmd_3344", {16'd0, bus.cmd}, 32'h3344);
    clr_pulse();

    // Reset in the middle of a transmission.
    send(8'h5A);
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_TX",        {31'd0, TX},            32'd1);
    chk("rst_mid_resp_sent", {31'd0, bus.resp_sent}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h5A);
    pulses = 0;
    for (int i = 0; i < 10 * B + 10; i++) begin
      @(negedge clk);
      if (bus.resp_sent) pulses++;
    end
    chk("resend_pulses", pulses, 1);

    // Randomized full-duplex traffic.
    for (int it = 0; it < 6; it++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      fork
        begin
          rx_frame(a, 1'b1);
          if ($urandom_range(0, 1) == 1) clr_pulse();
          repeat ($urandom_range(1, 40)) @(negedge clk);
          rx_frame(b, 1'b1);
          wait_rdy("rdy_rand", 40);
          chk("cmd_rand", {16'd0, bus.cmd}, {16'd0, a, b});
          repeat ($urandom_range(0, 20)) @(negedge clk);
          clr_pulse();
        end
        begin
          repeat ($urandom_range(0, 60)) @(negedge clk);
          send(8'($urandom));
          wait_sent("sent_rand", 10 * B + 20);
        end
      join
    end

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
